// File: rtl/sisc_pkg.sv
// sisc_pkg: definitions shared by the SISC instruction fetch unit and the control FSM.
//   - opcode constants
//   - IR field positions
//   - fetch FSM state encoding
package sisc_pkg;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  // IR layout: opcode [31:28], mm [27:24], imm [15:0]
  localparam int OP_LSB  = 28;
  localparam int MM_LSB  = 24;
  localparam int IMM_LSB = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sisc_ifetch_if.sv
// sisc_ifetch_if: instruction-memory read bus.
//   imem_rd    : read request, held for the whole transaction
//   imem_addr  : read address
//   imem_rdata : read data, valid when imem_ack is high
//   imem_ack   : read data valid this cycle
// The master modport belongs to the fetch unit; the slave modport belongs to the memory.
interface sisc_ifetch_if #(
  parameter int ADDR_W = 16
);
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ack;

  modport master (output imem_rd, imem_addr, input  imem_rdata, imem_ack);
  modport slave  (input  imem_rd, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/sisc_br_cond.sv
// sisc_br_cond: branch condition decoder (purely combinational).
//   opcode, mm, stat : current instruction fields and the status flags
//   take             : the branch is taken
//   relative         : the target is pc + sign-extended imm, not the absolute imm
module sisc_br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       take,
  output logic       relative
);

  logic hit;
  assign hit = |(stat & mm);

  always_comb begin
    take     = 1'b0;
    relative = 1'b0;
    case (opcode)
      OP_BRA: take = hit;
      OP_BRR: begin take = hit;  relative = 1'b1; end
      OP_BNE: take = !hit;
      OP_BNR: begin take = !hit; relative = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: instruction fetch and program counter unit.
//   clk, rst_f          : clock; synchronous active-high reset
//   fetch_req, br_eval  : one-cycle pulses from control
//   stat                : status flags used by branch evaluation
//   imem                : instruction-memory read bus (master side)
//   ir, opcode, mm, imm : instruction register and its decoded fields
//   ir_valid            : IR holds a completed fetch (or a NOOP after a timeout)
//   pc                  : program counter; it already points past the fetched instruction
//   busy, fetch_err     : fetch in progress; sticky timeout flag
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int          TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_req,
  input  logic              br_eval,
  input  logic [3:0]        stat,
  sisc_ifetch_if.master     imem,
  output logic [31:0]       ir,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [15:0]       imm,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e      state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              fetch_go, ld_ir, ld_nop, cnt_inc, br_ld;
  logic              take, relative;
  logic [ADDR_W-1:0] imm_abs, imm_sx, br_target;

  assign opcode = ir[OP_LSB +: 4];
  assign mm     = ir[MM_LSB +: 4];
  assign imm    = ir[IMM_LSB +: 16];

  assign busy           = (state == S_WAIT);
  assign imem.imem_rd   = (state == S_WAIT);
  assign imem.imem_addr = pc;

  sisc_br_cond u_br_cond (
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .take     (take),
    .relative (relative)
  );

  // imm adapted to the PC width: zero-extended for absolute targets,
  // sign-extended for relative offsets (truncated when ADDR_W < 16)
  if (ADDR_W <= 16) begin : g_imm_narrow
    assign imm_abs = imm[ADDR_W-1:0];
    assign imm_sx  = imm[ADDR_W-1:0];
  end else begin : g_imm_wide
    assign imm_abs = {{(ADDR_W-16){1'b0}}, imm};
    assign imm_sx  = {{(ADDR_W-16){imm[15]}}, imm};
  end

  assign br_target = relative ? pc + imm_sx : imm_abs;

  always_ff @(posedge clk) begin
    if (rst_f) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fetch_go = 1'b0;
    ld_ir    = 1'b0;
    ld_nop   = 1'b0;
    cnt_inc  = 1'b0;
    br_ld    = 1'b0;
    case (state)
      S_IDLE: begin
        // a valid branch evaluation swallows a coincident fetch_req
        if (br_eval && ir_valid) begin
          br_ld = take;
        end else if (fetch_req) begin
          fetch_go = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_ack) begin
          ld_ir    = 1'b1;
          state_nx = S_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // this cycle is the TIMEOUT-th with imem_rd high
          ld_nop   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      pc        <= ADDR_W'(RESET_PC);
      ir        <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      cnt       <= '0;
    end else begin
      if (fetch_go) begin
        ir_valid <= 1'b0;
        cnt      <= '0;
      end
      if (cnt_inc) cnt <= cnt + 1'b1;
      if (ld_ir) begin
        ir       <= imem.imem_rdata;
        ir_valid <= 1'b1;
        pc       <= pc + 1'b1;
      end
      if (ld_nop) begin
        ir        <= {OP_NOOP, 28'd0};
        ir_valid  <= 1'b1;
        fetch_err <= 1'b1;
      end
      if (br_ld) pc <= br_target;
    end
  end

endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: directed and random fetch/branch traffic against a
// transaction-level model of the PC, IR and error flag.
module tb_sisc_ifetch;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        fetch_req = 1'b0;
  logic        br_eval = 1'b0;
  logic [3:0]  stat = 4'h0;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;
  logic [15:0] imm;
  logic        ir_valid, busy, fetch_err;
  logic [15:0] pc;

  sisc_ifetch_if #(.ADDR_W(16)) imem_bus ();

  sisc_ifetch #(.ADDR_W(16), .RESET_PC(0), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .fetch_req (fetch_req),
    .br_eval   (br_eval),
    .stat      (stat),
    .imem      (imem_bus),
    .ir        (ir),
    .opcode    (opcode),
    .mm        (mm),
    .imm       (imm),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  int          m_pc;
  logic [31:0] m_ir;
  bit          m_vld, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"},     32'(pc),        32'(m_pc));
    chk({tag, ".ir"},     ir,             m_ir);
    chk({tag, ".vld"},    32'(ir_valid),  32'(m_vld));
    chk({tag, ".err"},    32'(fetch_err), 32'(m_err));
    chk({tag, ".op"},     32'(opcode),    32'(m_ir[31:28]));
    chk({tag, ".mm"},     32'(mm),        32'(m_ir[27:24]));
    chk({tag, ".imm"},    32'(imm),       32'(m_ir[15:0]));
    chk({tag, ".busy"},   32'(busy),      32'd0);
    chk({tag, ".rd"},     32'(imem_bus.imem_rd), 32'd0);
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = '0; m_vld = 0; m_err = 0;
  endtask

  // lat = cycle (1-based, after the request edge) in which ack is driven;
  // lat of 0 or beyond TMO means the memory never answers in time
  task automatic do_fetch(input int lat, input logic [31:0] data);
    int rd_n, bz_n, exp_n;
    rd_n = 0; bz_n = 0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int k = 1; k <= 40 && busy; k++) begin
      if (imem_bus.imem_rd) rd_n++;
      bz_n++;
      if (k == 1) chk("addr", 32'(imem_bus.imem_addr), 32'(m_pc));
      imem_bus.imem_ack   = (k == lat);
      imem_bus.imem_rdata = (k == lat) ? data : $urandom;
      step();
    end
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom;
    if (lat >= 1 && lat <= TMO) begin
      m_ir = data; m_vld = 1; m_pc = (m_pc + 1) & 16'hFFFF; exp_n = lat;
    end else begin
      m_ir = '0; m_vld = 1; m_err = 1; exp_n = TMO;
    end
    chk("busy_cycles", 32'(bz_n), 32'(exp_n));
    chk("rd_cycles",   32'(rd_n), 32'(exp_n));
    chk_state("fetch");
  endtask

  task automatic do_branch(input logic [3:0] s, input bit with_req);
    logic signed [15:0] off;
    bit hit;
    br_eval   = 1'b1;
    fetch_req = with_req;
    stat      = s;
    step();
    br_eval   = 1'b0;
    fetch_req = 1'b0;
    if (m_vld) begin
      hit = (s & m_ir[27:24]) != 4'h0;
      off = m_ir[15:0];
      case (m_ir[31:28])
        4'd4: if (hit)  m_pc = int'(m_ir[15:0]);
        4'd5: if (hit)  m_pc = (m_pc + int'(off)) & 16'hFFFF;
        4'd6: if (!hit) m_pc = int'(m_ir[15:0]);
        4'd7: if (!hit) m_pc = (m_pc + int'(off)) & 16'hFFFF;
        default: ;
      endcase
    end
    chk_state(with_req ? "br_req" : "br");
  endtask

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    model_reset();

    // reset held for two cycles
    rst_f = 1'b1;
    step(); step();
    rst_f = 1'b0;
    chk_state("reset");

    // branch with nothing fetched is ignored
    do_branch(4'hF, 1'b0);

    // ack while idle is ignored
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h4F00_1234;
    step();
    imem_bus.imem_ack = 1'b0;
    chk_state("idle_ack");

    // minimum-latency fetch
    do_fetch(1, 32'h8123_0005);
    chk("first.op", 32'(opcode), 32'd8);
    chk("first.pc", 32'(pc), 32'd1);

    // delayed ack with garbage on rdata beforehand
    do_fetch(6, 32'h0000_1234);

    // timeout
    do_fetch(0, 32'hDEAD_BEEF);

    // BRR taken / not taken from pc 0x0010
    do_fetch(2, 32'h4100_000F); do_branch(4'h1, 1'b0);
    do_fetch(1, 32'h5200_FFFC); do_branch(4'h2, 1'b0);
    chk("brr_taken", 32'(pc), 32'h000C);
    do_fetch(1, 32'h4100_000F); do_branch(4'h1, 1'b0);
    do_fetch(1, 32'h5200_FFFC); do_branch(4'h0, 1'b0);
    chk("brr_not", 32'(pc), 32'h0010);

    // BNE taken
    do_fetch(3, 32'h6100_0040); do_branch(4'h0, 1'b0);

    // PC wrap
    do_fetch(1, 32'h4F00_FFFF); do_branch(4'h1, 1'b0);
    do_fetch(1, 32'h8000_0000);
    chk("wrap", 32'(pc), 32'h0000);

    // simultaneous fetch_req and br_eval: branch wins, no read
    do_fetch(1, 32'h6100_0020);
    do_branch(4'h0, 1'b1);

    // reset in the middle of a fetch, then a stray ack
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    step(); step();
    rst_f = 1'b1; step(); rst_f = 1'b0;
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = $urandom;
    step();
    imem_bus.imem_ack = 1'b0;
    model_reset();
    chk_state("mid_rst");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [31:0] d;
        d = $urandom;
        if ($urandom_range(0, 1) != 0) d[31:28] = 4'(4 + $urandom_range(0, 3));
        do_fetch($urandom_range(1, 17), d);
      end else begin
        do_branch(4'($urandom), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
